// File: rtl/mbist_wb_mem_req.sv
// Wishbone slave that turns single-beat transfers into one-cycle requests on the shared
// MBIST SRAM request bus; out-of-range SRAM selects end locally with a bus error.
module mbist_wb_mem_req #(
  parameter int unsigned BIST_NO_SRAM = 4,
  parameter int unsigned BIST_ADDR_WD = 10,
  parameter int unsigned BIST_DATA_WD = 32,
  parameter int unsigned READ_LAT     = 1,
  localparam int unsigned CS_WD       = (BIST_NO_SRAM + 1) / 2,
  localparam int unsigned AW          = BIST_ADDR_WD + CS_WD + 2,
  localparam int unsigned SEL_WD      = BIST_DATA_WD / 8
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [AW-1:0]           wb_adr_i,
  input  logic                    wb_we_i,
  input  logic [BIST_DATA_WD-1:0] wb_dat_i,
  input  logic [SEL_WD-1:0]       wb_sel_i,
  output logic [BIST_DATA_WD-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [CS_WD-1:0]        mem_cs,
  output logic                    mem_req,
  output logic [BIST_ADDR_WD-1:0] mem_addr,
  output logic                    mem_we,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  output logic [SEL_WD-1:0]       mem_wmask,
  input  logic [BIST_DATA_WD-1:0] mem_rdata
);

  localparam int unsigned CNT_WD = 2;
  localparam logic [CNT_WD-1:0] CNT_LOAD = CNT_WD'(READ_LAT - 1);
  // One extra bit so BIST_NO_SRAM itself is representable next to the select field.
  localparam logic [CS_WD:0] NUM_SRAM = (CS_WD + 1)'(BIST_NO_SRAM);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StAck, StErr} state_e;

  state_e state_q, state_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;

  logic [BIST_DATA_WD-1:0] dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [CS_WD-1:0]        cs_q, cs_d;
  logic                    req_q, req_d;
  logic [BIST_ADDR_WD-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [BIST_DATA_WD-1:0] wdata_q, wdata_d;
  logic [SEL_WD-1:0]       wmask_q, wmask_d;

  logic                    strobe;
  logic [CS_WD-1:0]        adr_sel;
  logic [BIST_ADDR_WD-1:0] adr_word;
  logic                    sel_ok;
  logic                    unused_adr;

  assign strobe     = wb_cyc_i & wb_stb_i;
  assign adr_sel    = wb_adr_i[AW-1:BIST_ADDR_WD+2];
  assign adr_word   = wb_adr_i[BIST_ADDR_WD+1:2];
  assign sel_ok     = {1'b0, adr_sel} < NUM_SRAM;
  assign unused_adr = ^wb_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (strobe) state_d = sel_ok ? StReq : StErr;
      // mem_we is high in StReq exactly when the issued request is a write.
      StReq: begin
        if (we_q) begin
          state_d = StAck;
        end else begin
          state_d = StWait;
          cnt_d   = CNT_LOAD;
        end
      end
      StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, decided from the current state.
  always_comb begin
    dat_d   = dat_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    req_d   = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          cs_d    = adr_sel;
          addr_d  = adr_word;
          wdata_d = wb_dat_i;
          wmask_d = wb_we_i ? wb_sel_i : '0;
          if (sel_ok) begin
            req_d = 1'b1;
            we_d  = wb_we_i;
          end else begin
            err_d = 1'b1;
            dat_d = '0;
          end
        end
      end
      StReq: ack_d = we_q;
      StWait: begin
        if (wb_cyc_i && cnt_q == '0) begin
          ack_d = 1'b1;
          dat_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign mem_cs    = cs_q;
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mbist_wb_mem_req.sv
// Bench for mbist_wb_mem_req: a default instance backed by an SRAM model, and a
// three-SRAM, latency-3 instance for error, latency, abort and reset cases.
module tb_mbist_wb_mem_req;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cyc_a, stb_a, cyc_b, stb_b, we;
  logic [AW-1:0] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;

  logic [31:0] dat_o_a, wdata_a, rdata_a, dat_o_b, wdata_b, rdata_b;
  logic        ack_a, err_a, req_a, mwe_a, ack_b, err_b, req_b, mwe_b;
  logic [1:0]  cs_a, cs_b;
  logic [9:0]  addr_a, addr_b;
  logic [3:0]  wmask_a, wmask_b;

  mbist_wb_mem_req u_dut_a (
    .wb_clk_i(clk), .rst_n(rst_n), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_adr_i(adr),
    .wb_we_i(we), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_a), .wb_ack_o(ack_a),
    .wb_err_o(err_a), .mem_cs(cs_a), .mem_req(req_a), .mem_addr(addr_a), .mem_we(mwe_a),
    .mem_wdata(wdata_a), .mem_wmask(wmask_a), .mem_rdata(rdata_a)
  );

  mbist_wb_mem_req #(.BIST_NO_SRAM(3), .READ_LAT(3)) u_dut_b (
    .wb_clk_i(clk), .rst_n(rst_n), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_adr_i(adr),
    .wb_we_i(we), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_b), .wb_ack_o(ack_b),
    .wb_err_o(err_b), .mem_cs(cs_b), .mem_req(req_b), .mem_addr(addr_b), .mem_we(mwe_b),
    .mem_wdata(wdata_b), .mem_wmask(wmask_b), .mem_rdata(rdata_b)
  );

  // SRAM model for instance A: captures at the request edge, read data valid one cycle later.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (req_a) begin
      tmp = mem[{cs_a, addr_a}];
      if (mwe_a) begin
        for (int i = 0; i < 4; i++) if (wmask_a[i]) tmp[8*i +: 8] = wdata_a[8*i +: 8];
        mem[{cs_a, addr_a}] <= tmp;
      end else begin
        rdata_a <= tmp;
      end
    end
  end

  logic        use_b;
  logic [31:0] o_dat, o_wdata;
  logic        o_ack, o_err, o_req, o_we;
  logic [1:0]  o_cs;
  logic [9:0]  o_addr;
  logic [3:0]  o_wmask;
  assign o_dat   = use_b ? dat_o_b : dat_o_a;
  assign o_wdata = use_b ? wdata_b : wdata_a;
  assign o_ack   = use_b ? ack_b : ack_a;
  assign o_err   = use_b ? err_b : err_a;
  assign o_req   = use_b ? req_b : req_a;
  assign o_we    = use_b ? mwe_b : mwe_a;
  assign o_cs    = use_b ? cs_b : cs_a;
  assign o_addr  = use_b ? addr_b : addr_a;
  assign o_wmask = use_b ? wmask_b : wmask_a;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Results of the last xfer: cycles from strobe to ack/err, request fields seen.
  int          lat, nreq, n_extra;
  logic        got_ack, got_err, r_we;
  logic [1:0]  r_cs;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    @(negedge clk);
    we = w; adr = a; dat = d; sel = s;
    if (use_b) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else begin cyc_a = 1'b1; stb_a = 1'b1; end
    lat = 0; nreq = 0; n_extra = 0; got_ack = 1'b0; got_err = 1'b0;
    for (int k = 1; k <= 20 && !got_ack && !got_err; k++) begin
      @(negedge clk);
      lat = k;
      // Tag each cycle's read data so the captured cycle is identifiable.
      if (use_b) rdata_b = 32'hC0DE_0000 | 32'(k);
      if (o_req) begin
        nreq++;
        r_cs = o_cs; r_addr = o_addr; r_we = o_we; r_wdata = o_wdata; r_wmask = o_wmask;
      end
      if (o_ack && o_err) n_extra++;
      got_ack = o_ack;
      got_err = o_err;
    end
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_req) nreq++;
      if (o_ack || o_err) n_extra++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  cs;
    logic [9:0]  wa;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   req_t [4];
    int   bb_req, bb_ack, bb_extra;

    vecs[0] = '{1'b1, 2'd2, 10'h155, 2'd0, 32'hA5A5_1234, 4'hF, 4'hF, 32'h0, 2};
    vecs[1] = '{1'b0, 2'd2, 10'h155, 2'd0, 32'h0, 4'hF, 4'h0, 32'hA5A5_1234, 3};
    vecs[2] = '{1'b1, 2'd1, 10'h0AA, 2'd0, 32'h1122_3344, 4'hF, 4'hF, 32'h0, 2};
    vecs[3] = '{1'b1, 2'd1, 10'h0AA, 2'd0, 32'hAABB_CCDD, 4'h5, 4'h5, 32'h0, 2};
    vecs[4] = '{1'b0, 2'd1, 10'h0AA, 2'd0, 32'h0, 4'hF, 4'h0, 32'h11BB_33DD, 3};
    vecs[5] = '{1'b1, 2'd0, 10'h3FF, 2'd0, 32'hDEAD_BEEF, 4'hA, 4'hA, 32'h0, 2};
    vecs[6] = '{1'b0, 2'd0, 10'h3FF, 2'd0, 32'h0, 4'hF, 4'h0, 32'hDE00_BE00, 3};
    vecs[7] = '{1'b1, 2'd3, 10'h001, 2'd0, 32'hFFFF_FFFF, 4'h3, 4'h3, 32'h0, 2};
    vecs[8] = '{1'b0, 2'd2, 10'h155, 2'd3, 32'h0, 4'hF, 4'h0, 32'hA5A5_1234, 3};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst_n = 1'b0; use_b = 1'b0; rdata_b = 32'h0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    we = 1'b0; adr = '0; dat = 32'h0; sel = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_a_ctrl", {ack_a, err_a, req_a, mwe_a}, 0);
    check("rst_a_bus", {cs_a, addr_a, wmask_a} | dat_o_a | wdata_a, 0);
    check("rst_b_all", {ack_b, err_b, req_b, mwe_b, cs_b, addr_b, wmask_b} | dat_o_b, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].w, {vecs[i].cs, vecs[i].wa, vecs[i].lo}, vecs[i].d, vecs[i].s);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ack", i), {got_ack, got_err}, 2'b10);
      check($sformatf("v%0d_nreq", i), nreq, 1);
      check($sformatf("v%0d_extra", i), n_extra, 0);
      check($sformatf("v%0d_cs", i), r_cs, vecs[i].cs);
      check($sformatf("v%0d_addr", i), r_addr, vecs[i].wa);
      check($sformatf("v%0d_we", i), r_we, vecs[i].w);
      check($sformatf("v%0d_wmask", i), r_wmask, vecs[i].exp_mask);
      if (vecs[i].w) check($sformatf("v%0d_wdata", i), r_wdata, vecs[i].d);
      else check($sformatf("v%0d_rdata", i), dat_o_a, vecs[i].exp_rd);
    end

    // Four writes with the strobe held high; address advances as each ack is seen.
    bb_req = 0; bb_ack = 0; bb_extra = 0;
    @(negedge clk);
    cyc_a = 1'b1; stb_a = 1'b1; we = 1'b1; sel = 4'hF;
    adr = {2'd0, 10'h010, 2'd0}; dat = 32'h0000_1000;
    for (int k = 1; k <= 40 && bb_ack < 4; k++) begin
      @(negedge clk);
      if (req_a) begin
        if (bb_req < 4) req_t[bb_req] = k;
        bb_req++;
      end
      if (ack_a) begin
        bb_ack++;
        adr = {2'd0, 10'h010 + 10'(bb_ack), 2'd0};
        dat = 32'h0000_1000 + 32'(bb_ack);
      end
    end
    cyc_a = 1'b0; stb_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_a || ack_a) bb_extra++;
    end
    check("b2b_nreq", bb_req, 4);
    check("b2b_nack", bb_ack, 4);
    check("b2b_extra", bb_extra, 0);
    check("b2b_gap0", req_t[1] - req_t[0], 3);
    check("b2b_gap1", req_t[2] - req_t[1], 3);
    check("b2b_gap2", req_t[3] - req_t[2], 3);
    xfer(1'b0, {2'd0, 10'h012, 2'd0}, 32'h0, 4'hF);
    check("b2b_readback", dat_o_a, 32'h0000_1002);

    // Latency 3: data driven in the cycle before E4 is the one captured.
    use_b = 1'b1;
    xfer(1'b0, {2'd1, 10'h005, 2'd0}, 32'h0, 4'hF);
    check("lat3_lat", lat, 5);
    check("lat3_ack", {got_ack, got_err}, 2'b10);
    check("lat3_nreq", nreq, 1);
    check("lat3_data", dat_o_b, 32'hC0DE_0004);

    // Select 3 with three SRAMs: local error, no request, read data cleared.
    xfer(1'b1, {2'd3, 10'h2AA, 2'd0}, 32'hFFFF_FFFF, 4'hF);
    check("err_lat", lat, 1);
    check("err_flags", {got_ack, got_err}, 2'b01);
    check("err_nreq", nreq, 0);
    check("err_extra", n_extra, 0);
    check("err_data", dat_o_b, 32'h0);

    // Drop the cycle while waiting for read data.
    @(negedge clk);
    cyc_b = 1'b1; stb_b = 1'b1; we = 1'b0; adr = {2'd0, 10'h007, 2'd0};
    repeat (2) @(negedge clk);
    cyc_b = 1'b0; stb_b = 1'b0;
    bb_extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_b || err_b || req_b) bb_extra++;
    end
    check("abort_no_ack", bb_extra, 0);
    xfer(1'b1, {2'd2, 10'h033, 2'd0}, 32'h5555_AAAA, 4'hC);
    check("abort_next_lat", lat, 2);
    check("abort_next_ack", {got_ack, got_err}, 2'b10);
    check("abort_next_wmask", r_wmask, 4'hC);

    // Asynchronous reset while instance B waits for read data.
    @(negedge clk);
    cyc_b = 1'b1; stb_b = 1'b1; we = 1'b0; adr = {2'd1, 10'h123, 2'd0};
    repeat (2) @(negedge clk);
    check("pre_rst_addr", addr_b, 10'h123);
    rst_n = 1'b0;
    #1;
    check("rst_b_ctrl", {ack_b, err_b, req_b, mwe_b}, 0);
    check("rst_b_addr", {cs_b, addr_b}, 0);
    check("rst_b_data", dat_o_b | wdata_b | 32'(wmask_b), 0);
    check("rst_a_data", dat_o_a | 32'({cs_a, addr_a}), 0);
    @(negedge clk);
    cyc_b = 1'b0; stb_b = 1'b0;
    rst_n = 1'b1;
    bb_extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_b || err_b || req_b) bb_extra++;
    end
    check("post_rst_quiet", bb_extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
